// File: rtl/branch_condition_pipe_pkg.sv
// Shared condition-code definitions for the branch-condition pipeline and
// the compare-flag logic that the ALU flag path will also use.
package branch_condition_pipe_pkg;

  // Jump masks, ordered {lt, eq, gt}
  localparam logic [2:0] COND_NEVER      = 3'b000;
  localparam logic [2:0] COND_ALWAYS     = 3'b111;
  localparam logic [2:0] COND_JLT        = 3'b100;
  localparam logic [2:0] COND_JEQ        = 3'b010;
  localparam logic [2:0] COND_JGT        = 3'b001;

  // Saved flags after reset read as "equal"
  localparam logic [2:0] SAVED_FLAGS_RST = 3'b010;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cond_flags_t;

  // A jump is taken when any selected relation holds; the all-ones mask is
  // an unconditional jump regardless of the flag contents.
  function automatic logic cond_taken(input cond_flags_t f, input logic [2:0] mask);
    logic hit_lt;
    logic hit_eq;
    logic hit_gt;
    hit_lt = f.lt & ((mask & COND_JLT) != COND_NEVER);
    hit_eq = f.eq & ((mask & COND_JEQ) != COND_NEVER);
    hit_gt = f.gt & ((mask & COND_JGT) != COND_NEVER);
    return hit_lt | hit_eq | hit_gt | (mask == COND_ALWAYS);
  endfunction

endpackage

// File: rtl/branch_condition_pipe_cmp_flags.sv
// Combinational comparator producing one-hot lt/eq/gt flags from a single
// BUS_WIDTH+1-bit subtraction, in signed or unsigned mode.
module cmp_flags #(
  parameter int BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] i_A,
  input  logic [BUS_WIDTH-1:0] i_B,
  input  logic                 i_unsigned,
  output logic                 o_lt,
  output logic                 o_eq,
  output logic                 o_gt
);

  logic [BUS_WIDTH:0] diff;
  logic               sign_n;
  logic               ovf_v;

  // One subtractor serves every flag: borrow for unsigned, N^V for signed,
  // and a zero low word for equality (A-B mod 2^W is zero only when A==B).
  always_comb begin
    diff   = {1'b0, i_A} - {1'b0, i_B};
    sign_n = diff[BUS_WIDTH-1];
    ovf_v  = (i_A[BUS_WIDTH-1] != i_B[BUS_WIDTH-1]) &&
             (diff[BUS_WIDTH-1] != i_A[BUS_WIDTH-1]);
    o_eq   = (diff[BUS_WIDTH-1:0] == '0);
    o_lt   = i_unsigned ? diff[BUS_WIDTH] : (sign_n ^ ovf_v);
    o_gt   = ~(o_lt | o_eq);
  end

endmodule

// File: rtl/branch_condition_pipe.sv
// Two-stage branch-condition unit: S1 captures flags and jump mask, S2
// resolves taken/not-taken and drives the registered outputs. Valid/ready
// on both sides lets the unit stall behind fetch/PC-update logic.
module branch_condition_pipe
  import branch_condition_pipe_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [BUS_WIDTH-1:0] i_A,
  input  logic [BUS_WIDTH-1:0] i_B,
  input  logic                 i_unsigned,
  input  logic                 i_use_saved,
  input  logic                 i_lt,
  input  logic                 i_eq,
  input  logic                 i_gt,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_taken,
  output logic                 o_lt,
  output logic                 o_eq,
  output logic                 o_gt
);

  cond_flags_t cmp_result;
  cond_flags_t req_flags;
  cond_flags_t saved_flags_reg;
  cond_flags_t s1_flags_reg;
  cond_flags_t s2_flags_reg;
  logic [2:0]  s1_mask_reg;
  logic        s1_valid_reg;
  logic        s2_valid_reg;
  logic        s2_taken_reg;
  logic        s2_advance;
  logic        accept;

  cmp_flags #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_cmp_flags (
    .i_A        (i_A),
    .i_B        (i_B),
    .i_unsigned (i_unsigned),
    .o_lt       (cmp_result.lt),
    .o_eq       (cmp_result.eq),
    .o_gt       (cmp_result.gt)
  );

  // S2 frees up when empty or being consumed; S1 can then always refill,
  // so o_ready sees i_ready combinationally to keep full throughput.
  assign s2_advance = ~s2_valid_reg | i_ready;
  assign o_ready    = ~s1_valid_reg | s2_advance;
  assign accept     = i_valid & o_ready;
  assign req_flags  = i_use_saved ? saved_flags_reg : cmp_result;

  // Saved flags track the most recent accepted real compare
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      saved_flags_reg <= cond_flags_t'(SAVED_FLAGS_RST);
    end else if (accept && !i_use_saved) begin
      saved_flags_reg <= cmp_result;
    end
  end

  // S1: capture a new request, or empty out once its entry moves to S2
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_reg <= 1'b0;
      s1_flags_reg <= '0;
      s1_mask_reg  <= COND_NEVER;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_flags_reg <= req_flags;
      s1_mask_reg  <= {i_lt, i_eq, i_gt};
    end else if (s2_advance) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // S2: resolve the jump and hold the result until downstream takes it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid_reg <= 1'b0;
      s2_taken_reg <= 1'b0;
      s2_flags_reg <= '0;
    end else if (s2_advance) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_taken_reg <= cond_taken(s1_flags_reg, s1_mask_reg);
        s2_flags_reg <= s1_flags_reg;
      end
    end
  end

  assign o_valid = s2_valid_reg;
  assign o_taken = s2_taken_reg;
  assign o_lt    = s2_flags_reg.lt;
  assign o_eq    = s2_flags_reg.eq;
  assign o_gt    = s2_flags_reg.gt;

endmodule

// File: tb/tb_branch_condition_pipe.sv
// Bench for branch_condition_pipe: directed cases with literal expectations
// plus randomized traffic checked against an in-order behavioural model.
module tb_branch_condition_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_A;
  logic [W-1:0] i_B;
  logic         i_unsigned;
  logic         i_use_saved;
  logic         i_lt;
  logic         i_eq;
  logic         i_gt;
  logic         o_valid;
  logic         i_ready;
  logic         o_taken;
  logic         o_lt;
  logic         o_eq;
  logic         o_gt;

  branch_condition_pipe #(.BUS_WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_A         (i_A),
    .i_B         (i_B),
    .i_unsigned  (i_unsigned),
    .i_use_saved (i_use_saved),
    .i_lt        (i_lt),
    .i_eq        (i_eq),
    .i_gt        (i_gt),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_taken     (o_taken),
    .o_lt        (o_lt),
    .o_eq        (o_eq),
    .o_gt        (o_gt)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];
  logic [2:0] model_saved;
  logic       saw_stall;
  logic       hold_prev;
  logic [3:0] prev_out;
  logic       rand_on;
  logic [3:0] dut_out;

  assign dut_out = {o_taken, o_lt, o_eq, o_gt};

  // Reference relation between two operands, returned as {lt,eq,gt}
  function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic uns);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (a == b) return 3'b010;
    if (uns) return (a < b) ? 3'b100 : 3'b001;
    return (sa < sb) ? 3'b100 : 3'b001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_obs(input int idx, input logic [3:0] exp, input string name);
    if (idx >= obs_q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s: result %0d missing, only %0d seen", name, idx, obs_q.size());
    end else begin
      chk(name, obs_q[idx], exp);
    end
  endtask

  // Per-cycle checker: in-order results vs model, hold stability, readiness
  initial begin
    logic [2:0] f;
    logic [2:0] m;
    hold_prev = 1'b0;
    prev_out  = '0;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("hold_valid", o_valid, 1);
          chk("hold_data", dut_out, prev_out);
        end
        if (!o_valid || i_ready) chk("ready_when_s2_free", o_ready, 1);
        if (!o_ready) saw_stall = 1'b1;
        if (o_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_valid: got o_valid=1 expected no pending result");
          end else begin
            chk("result", dut_out, exp_q[0]);
          end
        end
        if (o_valid && i_ready) begin
          obs_q.push_back(dut_out);
          if (exp_q.size() != 0) exp_q.delete(0);
        end
        hold_prev = o_valid && !i_ready;
        prev_out  = dut_out;
        if (i_valid && o_ready) begin
          f = i_use_saved ? model_saved : ref_flags(i_A, i_B, i_unsigned);
          m = {i_lt, i_eq, i_gt};
          exp_q.push_back({((f & m) != 3'b000), f});
          if (!i_use_saved) model_saved = f;
        end
      end
    end
  end

  // Present one request (called just after a rising edge) until accepted
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic uns,
                      input logic us, input logic [2:0] mask);
    logic ok;
    i_A = a; i_B = b; i_unsigned = uns; i_use_saved = us;
    {i_lt, i_eq, i_gt} = mask;
    i_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got o_ready=0 for 50 cycles expected acceptance");
    end
    @(posedge clk);
    #1;
  endtask

  // Drop valid and scramble the request inputs, which must be ignored
  task automatic idle(input int cycles);
    i_valid = 1'b0;
    i_A = W'($urandom); i_B = W'($urandom);
    i_unsigned = 1'($urandom); i_use_saved = 1'($urandom);
    {i_lt, i_eq, i_gt} = 3'($urandom);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !o_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_A = '0; i_B = '0; i_unsigned = 1'b0; i_use_saved = 1'b0;
    i_lt = 1'b0; i_eq = 1'b0; i_gt = 1'b0;
    model_saved = 3'b010; saw_stall = 1'b0; rand_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_outputs", dut_out, 4'b0000);
    chk("rst_o_ready", o_ready, 1);
    i_rst = 1'b0;
    @(posedge clk);
    #1;

    // Equal operands, jump-if-equal, two-cycle latency
    i_A = 8'h05; i_B = 8'h05; i_unsigned = 1'b0; i_use_saved = 1'b0;
    {i_lt, i_eq, i_gt} = 3'b010;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    chk("t1_valid_after_1", o_valid, 0);
    @(posedge clk);
    #1;
    chk("t1_valid_after_2", o_valid, 1);
    chk("t1_out", dut_out, 4'b1010);
    drain();

    // Signed vs unsigned interpretation, including the overflow path
    obs_q.delete();
    send(8'hFF, 8'h01, 1'b0, 1'b0, 3'b100);
    send(8'hFF, 8'h01, 1'b1, 1'b0, 3'b100);
    send(8'h80, 8'h7F, 1'b0, 1'b0, 3'b100);
    send(8'h80, 8'h7F, 1'b1, 1'b0, 3'b100);
    idle(1);
    drain();
    chk_obs(0, 4'b1100, "t2_signed_m1_lt_1");
    chk_obs(1, 4'b0001, "t2_unsigned_255_gt_1");
    chk_obs(2, 4'b1100, "t3_signed_m128_lt_127");
    chk_obs(3, 4'b0001, "t3_unsigned_128_gt_127");

    // Saved flags: set by a compare, read back-to-back, never modified
    obs_q.delete();
    send(8'h10, 8'h20, 1'b1, 1'b0, 3'b000);
    send(8'h00, 8'h00, 1'b0, 1'b1, 3'b001);
    send(8'hAA, 8'h55, 1'b0, 1'b1, 3'b111);
    send(8'h33, 8'h33, 1'b1, 1'b1, 3'b000);
    send(8'h01, 8'hFE, 1'b0, 1'b1, 3'b100);
    idle(1);
    drain();
    chk_obs(0, 4'b0100, "t5_cmp_lt_never");
    chk_obs(1, 4'b0100, "t5_saved_mask001");
    chk_obs(2, 4'b1100, "t5_saved_mask111");
    chk_obs(3, 4'b0100, "t5_saved_mask000");
    chk_obs(4, 4'b1100, "t5_saved_mask100");

    // Back-to-back issue into a stalled consumer
    obs_q.delete();
    saw_stall = 1'b0;
    fork
      begin
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b1;
      end
      begin
        send(8'h01, 8'h02, 1'b1, 1'b0, 3'b100);
        send(8'h03, 8'h03, 1'b1, 1'b0, 3'b010);
        send(8'h09, 8'h02, 1'b1, 1'b0, 3'b001);
        send(8'h07, 8'h08, 1'b0, 1'b0, 3'b000);
      end
    join
    idle(1);
    drain();
    chk("t4_saw_backpressure", saw_stall, 1);
    chk("t4_result_count", obs_q.size(), 4);
    chk_obs(0, 4'b1100, "t4_r0");
    chk_obs(1, 4'b1010, "t4_r1");
    chk_obs(2, 4'b1001, "t4_r2");
    chk_obs(3, 4'b0100, "t4_r3");

    // Asynchronous reset with both stages full
    i_ready = 1'b0;
    send(8'h02, 8'h01, 1'b1, 1'b0, 3'b001);
    send(8'h01, 8'h02, 1'b1, 1'b0, 3'b100);
    idle(0);
    chk("t6_full_before_rst", o_valid, 1);
    #2;
    i_rst = 1'b1;
    #1;
    chk("t6_valid_cleared_async", o_valid, 0);
    chk("t6_outputs_cleared", dut_out, 4'b0000);
    exp_q.delete();
    model_saved = 3'b010;
    i_ready = 1'b1;
    @(posedge clk);
    #2;
    i_rst = 1'b0;
    @(posedge clk);
    #1;
    obs_q.delete();
    send(8'h40, 8'h03, 1'b0, 1'b1, 3'b010);
    idle(1);
    drain();
    chk("t6_count_after_rst", obs_q.size(), 1);
    chk_obs(0, 4'b1010, "t6_saved_after_rst");

    // Randomized traffic with random backpressure
    rand_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          send(W'($urandom), ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom),
               1'($urandom), ($urandom_range(0, 3) == 0), 3'($urandom));
          if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          if (rand_on) i_ready = 1'($urandom);
        end
      end
    join
    i_ready = 1'b1;
    idle(1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
